// File: rtl/usb_cdc_rx_fifo.sv
// ---------------------------------------------------------------------------
// usb_cdc_rx_fifo
//
// Receive FIFO between the USB CDC OUT endpoint and a byte consumer.
// Bytes arrive as single-cycle strobes with no backpressure. They are stored
// in a synchronous-read memory (BRAM friendly). A first-word-fall-through
// output register presents them with a valid/ready handshake.
//
// Ports
//   clk         60 MHz USB core clock; all logic on the rising edge
//   rstn        synchronous active-low reset
//   usb_rstn    USB link state, 0 = disconnected (flushes the FIFO)
//   recv_data   byte from the CDC OUT endpoint
//   recv_valid  single-cycle strobe qualifying recv_data
//   out_data    byte presented to the consumer
//   out_valid   out_data holds a valid byte
//   out_ready   consumer accepts out_data this cycle
//   level       bytes held in memory, excluding the output register
//   overflow    sticky flag, set when a byte was dropped on a full FIFO
//   ovf_cnt     saturating dropped-byte count
//
// Configuration
//   USB_CDC_RX_OVF_CNT_EN  defined: ovf_cnt counts dropped bytes, saturating
//                          at 16'hFFFF. Undefined: ovf_cnt is tied to 0.
// ---------------------------------------------------------------------------
module usb_cdc_rx_fifo #(
   parameter int ASIZE = 10
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             usb_rstn,
   input  logic [7:0]       recv_data,
   input  logic             recv_valid,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ASIZE:0]   level,
   output logic             overflow,
   output logic [15:0]      ovf_cnt
);

   localparam int DEPTH = 1 << ASIZE;
   localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

   logic [7:0]       mem [DEPTH];
   logic [7:0]       rd_data;
   logic [ASIZE:0]   wptr;
   logic [ASIZE:0]   rptr;
   logic [ASIZE:0]   wptr_d;
   logic [ASIZE:0]   wptr_n;
   logic [ASIZE:0]   rptr_n;
   logic [ASIZE-1:0] rd_addr;
   logic             full;
   logic             avail;
   logic             take;
   logic             load;
   logic             wr_en;
   logic             drop;

   // Pointer arithmetic and handshake decisions. Full is taken from the
   // pre-edge pointers, so a read in the same cycle never rescues a write
   // into a full FIFO. The output register may only load a byte that the
   // read port has already captured: a byte written at one edge is visible
   // on rd_data after the next edge. Comparing rptr against the one-cycle
   // delayed write pointer enforces that.
   always_comb begin
      full    = (wptr == {~rptr[ASIZE], rptr[ASIZE-1:0]});
      avail   = (wptr_d != rptr);
      take    = out_valid & out_ready;
      load    = avail & (~out_valid | out_ready);
      wr_en   = rstn & usb_rstn & recv_valid & ~full;
      drop    = rstn & usb_rstn & recv_valid & full;
      wptr_n  = wr_en ? (wptr + PTR_ONE) : wptr;
      rptr_n  = load ? (rptr + PTR_ONE) : rptr;
      if (!usb_rstn) begin
         wptr_n = '0;
         rptr_n = '0;
      end
      rd_addr = rptr_n[ASIZE-1:0];
   end

   // Byte storage. No reset here so the array maps onto block RAM. The read
   // address follows the next read pointer, so rd_data always holds the
   // byte at the current head one cycle later.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wptr[ASIZE-1:0]] <= recv_data;
      end
      rd_data <= mem[rd_addr];
   end

   // Pointers, level, output register and the sticky overflow flag. A link
   // drop flushes pointers and discards the held output byte without a
   // transfer, but keeps the overflow history.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr      <= '0;
         rptr      <= '0;
         wptr_d    <= '0;
         level     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         wptr   <= wptr_n;
         rptr   <= rptr_n;
         wptr_d <= usb_rstn ? wptr : '0;
         level  <= wptr_n - rptr_n;
         if (!usb_rstn) begin
            out_valid <= 1'b0;
         end else if (load) begin
            out_data  <= rd_data;
            out_valid <= 1'b1;
         end else if (take) begin
            out_valid <= 1'b0;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

`ifdef USB_CDC_RX_OVF_CNT_EN
   logic [15:0] ovf_cnt_q;

   // Dropped-byte counter. It saturates instead of wrapping so a long
   // overrun never reads back as a small count. Only rstn clears it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ovf_cnt_q <= '0;
      end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
         ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
   end

   assign ovf_cnt = ovf_cnt_q;
`else
   assign ovf_cnt = 16'h0000;
`endif

endmodule

// File: doc/usb_cdc_rx_fifo.md
USB_CDC_RX_FIFO -- requirements
Module: usb_cdc_rx_fifo

Interface
REQ-001 Parameter ASIZE, default 10; memory depth = 2^ASIZE bytes; legal range 2..12.
REQ-002 rstn  input  1  synchronous active-low reset, sampled on rising clk.
REQ-003 clk  input  1  single clock (60 MHz USB core clock); all logic on its rising edge.
REQ-004 usb_rstn  input  1  USB link state from core; 0 = disconnected.
REQ-005 recv_data  input  8  byte from CDC OUT endpoint.
REQ-006 recv_valid  input  1  single-cycle strobe, recv_data valid; no backpressure possible.
REQ-007 out_data  output  8  byte presented to consumer.
REQ-008 out_valid  output  1  out_data holds a valid byte.
REQ-009 out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
REQ-010 level  output  ASIZE+1  bytes held in memory, excluding output register.
REQ-011 overflow  output  1  sticky flag, a byte was dropped.
REQ-012 ovf_cnt  output  16  dropped-byte count (present only per REQ-030).

Function
REQ-013 Pointers wptr/rptr SHALL be ASIZE+1 bits; wrap modulo 2^(ASIZE+1); memory index = low ASIZE bits.
REQ-014 empty SHALL be wptr==rptr; full SHALL be wptr=={~rptr[ASIZE],rptr[ASIZE-1:0]}.
REQ-015 level SHALL equal wptr-rptr, modulo 2^(ASIZE+1), registered with pointers.
REQ-016 recv_valid with !full SHALL write recv_data at wptr and increment wptr in that cycle.
REQ-017 recv_valid while full SHALL drop the byte, leave wptr unchanged, set overflow; full is evaluated on pre-edge state, so a simultaneous memory read does not rescue it.
REQ-018 Memory SHALL be synchronous-read (one-cycle latency) so it infers BRAM; output register SHALL form a first-word-fall-through stage.
REQ-019 Output register loads when memory non-empty and (out_valid==0 or out_valid&out_ready); load increments rptr.
REQ-020 Latency: byte written at edge N into empty FIFO with empty output register SHALL appear with out_valid=1 after edge N+2.
REQ-021 Sustained throughput: with out_ready=1 and continuous writes, one byte per cycle SHALL be delivered, no bubbles after first.
REQ-022 out_data/out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 out_valid deasserts after a transfer when memory empty; out_valid never asserts with unwritten data.
REQ-024 Byte order SHALL be preserved exactly; no byte duplicated or lost except per REQ-017.
REQ-025 usb_rstn==0 SHALL, at next edge, flush: wptr=rptr=0, out_valid=0, level=0; writes ignored while usb_rstn==0; overflow and ovf_cnt retained.
REQ-026 Flush mid-transfer SHALL discard held out_data without a transfer, regardless of out_ready.

Reset
REQ-027 rstn==0 at an edge SHALL set wptr=0, rptr=0, out_valid=0, out_data=0, level=0, overflow=0, ovf_cnt=0.
REQ-028 rstn dominates usb_rstn and all data inputs; memory contents not reset.
REQ-029 First write accepted at first edge with rstn=1 and usb_rstn=1.

Configuration
REQ-030 Macro USB_CDC_RX_OVF_CNT_EN: defined -> ovf_cnt increments by 1 per dropped byte, saturates at 16'hFFFF, cleared only by rstn; undefined -> ovf_cnt port driven constant 0, no counter logic, overflow flag unaffected.

Verification (bench ASIZE=4, depth 16)
REQ-031 Single write 8'hA5 to empty FIFO, out_ready=1 -> out_valid high exactly 2 edges later with 8'hA5, one cycle only, level returns 0.
REQ-032 out_ready=0, write 17 bytes 0x00..0x10 -> bytes 0x00 in output register, level=16, no drop; 18th write 0x11 -> overflow=1, ovf_cnt=1 (macro on) / 0 (off).
REQ-033 Then out_ready=1 -> sequence 0x00..0x10 delivered in order, one per cycle, 0x11 absent, out_valid drops after 0x10.
REQ-034 Write 40 bytes with random out_ready toggling -> output sequence equals input, pointers wrap past 31, level never exceeds 16.
REQ-035 Fill 5 bytes, pulse usb_rstn=0 one cycle with out_ready=0 -> out_valid=0, level=0 next cycle; overflow/ovf_cnt unchanged; next write 0x3C delivered 2 edges later.
REQ-036 Macro on, 65540 drops with FIFO held full -> ovf_cnt=16'hFFFF, overflow=1; rstn pulse -> all outputs zero.
